mac_periph_driver: RTL and testbench

MAC_PERIPH_DRIVER -- requirements
Module: mac_periph_driver

---
 rtl/mac_periph_driver_pkg.sv | 37 +++
 rtl/mac_periph_driver_xfer.sv | 51 +++++
 rtl/mac_periph_driver.sv | 198 +++++++++++++++++++
 tb/tb_mac_periph_driver.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_periph_driver_pkg.sv
// Shared types and register map for the MAC accelerator periph driver.
package mac_package;

    localparam logic [31:0] MAC_OFS_TRIGGER    = 32'h0000_0000;
    localparam logic [31:0] MAC_OFS_ACQUIRE    = 32'h0000_0004;
    localparam logic [31:0] MAC_OFS_SOFT_CLEAR = 32'h0000_0014;

    localparam int MAC_JOB_WORDS = 13;

    localparam logic [31:0] MAC_JOB_ADDR [MAC_JOB_WORDS] = '{
        32'h40, 32'h44, 32'h48, 32'h4C, 32'h50, 32'h54, 32'h58,
        32'h5C, 32'h60, 32'h64, 32'h68, 32'h6C, 32'h70
    };

    // Fields are declared MSB-first so that job word k sits at 32-bit slice k.
    typedef struct packed {
        logic [5:0][31:0] ucode;
        logic [31:0]      vectstride;
        logic [31:0]      len_iter;
        logic [31:0]      nb_iter;
        logic [3:0][31:0] ptr;
    } mac_job_t;

    typedef enum logic [1:0] {
        MAC_ERR_OK      = 2'd0,
        MAC_ERR_RETRY   = 2'd1,
        MAC_ERR_TIMEOUT = 2'd2,
        MAC_ERR_ABORT   = 2'd3
    } mac_err_e;

    function automatic logic [31:0] mac_job_word(mac_job_t job, logic [3:0] k);
        logic [MAC_JOB_WORDS-1:0][31:0] flat;
        flat = job;
        return flat[k];
    endfunction

endpackage

// File: rtl/mac_periph_driver_xfer.sv
// Single-outstanding periph initiator: latches a request on start and holds it
// stable until the responder grants it.
module mac_periph_xfer #(
    parameter int ID_WIDTH = 10
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [31:0]         add_i,
    input  logic                wen_i,
    input  logic [31:0]         data_i,
    output logic                gnt_o,
    output logic                periph_req_o,
    output logic [31:0]         periph_add_o,
    output logic                periph_wen_o,
    output logic [3:0]          periph_be_o,
    output logic [31:0]         periph_data_o,
    output logic [ID_WIDTH-1:0] periph_id_o,
    input  logic                periph_gnt_i
);

    logic        req_q;
    logic [31:0] add_q;
    logic        wen_q;
    logic [31:0] data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_q  <= 1'b0;
            add_q  <= '0;
            wen_q  <= 1'b1;
            data_q <= '0;
        end else if (req_q && periph_gnt_i) begin
            req_q <= 1'b0;
        end else if (!req_q && start_i) begin
            req_q  <= 1'b1;
            add_q  <= add_i;
            wen_q  <= wen_i;
            data_q <= data_i;
        end
    end

    assign gnt_o         = req_q & periph_gnt_i;
    assign periph_req_o  = req_q;
    assign periph_add_o  = add_q;
    assign periph_wen_o  = wen_q;
    assign periph_data_o = data_q;
    assign periph_be_o   = 4'hF;
    assign periph_id_o   = '0;

endmodule

// File: rtl/mac_periph_driver.sv
// Job sequencer for the MAC accelerator: acquire a context, program the job,
// trigger, then wait for the end event, a timeout or a software abort.
module mac_periph_driver
    import mac_package::*;
#(
    parameter int ID_WIDTH  = 10,
    parameter int MAX_RETRY = 16,
    parameter int TIMEOUT   = 65535
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                job_valid_i,
    output logic                job_ready_o,
    input  mac_job_t            job_i,
    output logic                periph_req_o,
    output logic [31:0]         periph_add_o,
    output logic                periph_wen_o,
    output logic [3:0]          periph_be_o,
    output logic [31:0]         periph_data_o,
    output logic [ID_WIDTH-1:0] periph_id_o,
    input  logic                periph_gnt_i,
    input  logic                periph_r_valid_i,
    input  logic [31:0]         periph_r_data_i,
    input  logic [ID_WIDTH-1:0] periph_r_id_i,
    input  logic                evt_i,
    input  logic                abort_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [1:0]          err_o,
    output logic [7:0]          ctx_id_o
);

    localparam int RW = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ACQ, S_ACQ_WAIT, S_PROG, S_TRIG, S_WAIT_EVT, S_CLEAR, S_DONE
    } state_e;

    state_e          state_q;
    mac_job_t        job_q;
    logic [3:0]      word_q;
    logic [RW-1:0]   retry_q;
    logic [31:0]     tmo_q;
    logic [7:0]      ctx_q;
    mac_err_e        err_q;
    logic            done_q, busy_q, ready_q;

    logic            xfer_start, xfer_wen, xfer_gnt;
    logic [31:0]     xfer_add, xfer_data;
    logic            tmo_hit, retry_last;
    logic            unused_rsp;

    assign unused_rsp = ^{periph_r_id_i, periph_r_data_i[30:8]};
    assign tmo_hit    = ({1'b0, tmo_q} + 33'd1) >= 33'(TIMEOUT);
    assign retry_last = (int'(retry_q) + 1) >= MAX_RETRY;

    // A new transfer is launched only once the previous one has been granted.
    always_comb begin
        xfer_start = 1'b0;
        xfer_add   = '0;
        xfer_wen   = 1'b0;
        xfer_data  = '0;
        case (state_q)
            S_ACQ: begin
                xfer_start = !periph_req_o;
                xfer_add   = MAC_OFS_ACQUIRE;
                xfer_wen   = 1'b1;
            end
            S_PROG: begin
                xfer_start = !periph_req_o;
                xfer_add   = MAC_JOB_ADDR[word_q];
                xfer_data  = mac_job_word(job_q, word_q);
            end
            S_TRIG: begin
                xfer_start = !periph_req_o;
                xfer_add   = MAC_OFS_TRIGGER;
            end
            S_CLEAR: begin
                xfer_start = !periph_req_o;
                xfer_add   = MAC_OFS_SOFT_CLEAR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            job_q   <= '0;
            word_q  <= '0;
            retry_q <= '0;
            tmo_q   <= '0;
            ctx_q   <= '0;
            err_q   <= MAC_ERR_OK;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (job_valid_i && ready_q) begin
                        job_q   <= job_i;
                        retry_q <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_ACQ;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                S_ACQ: if (xfer_gnt) state_q <= S_ACQ_WAIT;
                S_ACQ_WAIT: begin
                    if (periph_r_valid_i) begin
                        if (periph_r_data_i[31]) begin
                            if (int'(retry_q) < MAX_RETRY) retry_q <= retry_q + 1'b1;
                            if (retry_last) begin
                                err_q   <= MAC_ERR_RETRY;
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                state_q <= S_ACQ;
                            end
                        end else begin
                            ctx_q   <= periph_r_data_i[7:0];
                            word_q  <= '0;
                            state_q <= S_PROG;
                        end
                    end
                end
                S_PROG: begin
                    if (xfer_gnt) begin
                        word_q <= word_q + 4'd1;
                        if (word_q == 4'(MAC_JOB_WORDS - 1)) state_q <= S_TRIG;
                    end
                end
                S_TRIG: begin
                    if (xfer_gnt) begin
                        tmo_q   <= '0;
                        state_q <= S_WAIT_EVT;
                    end
                end
                // Priority: event beats abort, abort beats timeout.
                S_WAIT_EVT: begin
                    if (evt_i) begin
                        err_q   <= MAC_ERR_OK;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (abort_i) begin
                        err_q   <= MAC_ERR_ABORT;
                        state_q <= S_CLEAR;
                    end else if (tmo_hit) begin
                        err_q   <= MAC_ERR_TIMEOUT;
                        state_q <= S_CLEAR;
                    end else if (tmo_q != '1) begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
                S_CLEAR: begin
                    if (xfer_gnt) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    mac_periph_xfer #(.ID_WIDTH(ID_WIDTH)) u_xfer (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (xfer_start),
        .add_i         (xfer_add),
        .wen_i         (xfer_wen),
        .data_i        (xfer_data),
        .gnt_o         (xfer_gnt),
        .periph_req_o  (periph_req_o),
        .periph_add_o  (periph_add_o),
        .periph_wen_o  (periph_wen_o),
        .periph_be_o   (periph_be_o),
        .periph_data_o (periph_data_o),
        .periph_id_o   (periph_id_o),
        .periph_gnt_i  (periph_gnt_i)
    );

    assign job_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign ctx_id_o    = ctx_q;

endmodule

// File: tb/tb_mac_periph_driver.sv
// Directed job scenarios against a transaction-level model of the periph traffic.
module tb_mac_periph_driver;
    import mac_package::*;

    localparam int IDW  = 10;
    localparam int MAXR = 16;
    localparam int TMO  = 100;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            job_valid_i = 1'b0;
    logic            job_ready_o;
    mac_job_t        job_i = '0;
    logic            periph_req_o;
    logic [31:0]     periph_add_o;
    logic            periph_wen_o;
    logic [3:0]      periph_be_o;
    logic [31:0]     periph_data_o;
    logic [IDW-1:0]  periph_id_o;
    logic            periph_gnt_i = 1'b0;
    logic            periph_r_valid_i = 1'b0;
    logic [31:0]     periph_r_data_i = '0;
    logic [IDW-1:0]  periph_r_id_i = '0;
    logic            evt_i = 1'b0;
    logic            abort_i = 1'b0;
    logic            busy_o, done_o;
    logic [1:0]      err_o;
    logic [7:0]      ctx_id_o;

    int checks = 0, errors = 0, cyc = 0;

    mac_periph_driver #(.ID_WIDTH(IDW), .MAX_RETRY(MAXR), .TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_i(job_i),
        .periph_req_o(periph_req_o), .periph_add_o(periph_add_o), .periph_wen_o(periph_wen_o),
        .periph_be_o(periph_be_o), .periph_data_o(periph_data_o), .periph_id_o(periph_id_o),
        .periph_gnt_i(periph_gnt_i), .periph_r_valid_i(periph_r_valid_i),
        .periph_r_data_i(periph_r_data_i), .periph_r_id_i(periph_r_id_i),
        .evt_i(evt_i), .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o),
        .err_o(err_o), .ctx_id_o(ctx_id_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Responder state and the log of granted transactions.
    logic [31:0] acq_q[$];
    logic [31:0] acq_dflt = 32'hFFFF_FFFF;
    bit          hold_gnt = 1'b0;
    int          gwait = -1, rdly = 0;
    logic [31:0] s_add, s_data;
    logic        s_wen;
    logic [31:0] lg_add[$], lg_data[$];
    logic        lg_wen[$];
    int          trig_cyc = -1, clr_cyc = -1;
    logic [31:0] jw[13];

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    initial forever begin
        @(negedge clk_i);
        periph_r_valid_i = 1'b0;
        if (rst_i) begin
            periph_gnt_i = 1'b0;
            gwait = -1;
            rdly = 0;
        end else begin
            if (rdly > 0) begin
                rdly--;
                if (rdly == 0) begin
                    periph_r_valid_i = 1'b1;
                    periph_r_data_i = (acq_q.size() > 0) ? acq_q.pop_front() : acq_dflt;
                end
            end
            if (periph_gnt_i) begin
                periph_gnt_i = 1'b0;
                gwait = -1;
                lg_add.push_back(s_add);
                lg_wen.push_back(s_wen);
                lg_data.push_back(s_data);
                if (s_wen) rdly = $urandom_range(1, 3);
                if (!s_wen && s_add == MAC_OFS_TRIGGER) trig_cyc = cyc;
            end else if (periph_req_o) begin
                if (gwait < 0) begin
                    s_add = periph_add_o; s_wen = periph_wen_o; s_data = periph_data_o;
                    gwait = $urandom_range(0, 3);
                    if (!periph_wen_o && periph_add_o == MAC_OFS_SOFT_CLEAR) clr_cyc = cyc;
                    chk("be/id", {periph_be_o, 6'd0, periph_id_o}, {4'hF, 16'd0});
                end else begin
                    chk("req stable", {periph_add_o, periph_data_o, 31'd0, periph_wen_o},
                        {s_add, s_data, 31'd0, s_wen});
                end
                if (!hold_gnt) begin
                    if (gwait == 0) periph_gnt_i = 1'b1;
                    else gwait--;
                end
            end
        end
    end

    task automatic new_job();
        int n;
        for (int k = 0; k < 13; k++) jw[k] = $urandom;
        for (int i = 0; i < 4; i++) job_i.ptr[i] = jw[i];
        job_i.nb_iter    = jw[4];
        job_i.len_iter   = jw[5];
        job_i.vectstride = jw[6];
        for (int i = 0; i < 6; i++) job_i.ucode[i] = jw[7 + i];
        lg_add.delete(); lg_wen.delete(); lg_data.delete();
        trig_cyc = -1; clr_cyc = -1;
        n = 0;
        while (!job_ready_o && n < 20) begin tick(); n++; end
        chk("job_ready before accept", job_ready_o, 1);
        job_valid_i = 1'b1;
        tick();
        job_valid_i = 1'b0;
        chk("busy after accept", busy_o, 1);
        chk("ready low while busy", job_ready_o, 0);
    endtask

    task automatic wait_trig_pulse(input int dly, input logic ev, input logic ab);
        int n = 0;
        while (trig_cyc < 0 && n < 500) begin tick(); n++; end
        chk("trigger seen", trig_cyc >= 0, 1);
        repeat (dly) tick();
        evt_i = ev; abort_i = ab;
        tick();
        evt_i = 1'b0; abort_i = 1'b0;
    endtask

    task automatic wait_done(input logic [1:0] exp_err, input logic [7:0] exp_ctx);
        int n = 0;
        while (!done_o && n < 3000) begin tick(); n++; end
        chk("done pulse", done_o, 1);
        chk("err", err_o, exp_err);
        chk("ctx_id", ctx_id_o, exp_ctx);
        chk("busy in done", busy_o, 1);
        tick();
        chk("done one cycle", done_o, 0);
        chk("idle busy", busy_o, 0);
        chk("idle ready", job_ready_o, 1);
    endtask

    // Expected traffic: nreads ACQUIRE reads, then the job words, trigger and maybe soft clear.
    task automatic check_log(input int nreads, input bit wr, input bit clr);
        logic [31:0] ea[$], ed[$];
        logic        ew[$];
        int          m;
        for (int i = 0; i < nreads; i++) begin ea.push_back(32'h04); ew.push_back(1'b1); ed.push_back('0); end
        if (wr) begin
            for (int k = 0; k < 13; k++) begin
                ea.push_back(32'h40 + 32'(4 * k)); ew.push_back(1'b0); ed.push_back(jw[k]);
            end
            ea.push_back(32'h00); ew.push_back(1'b0); ed.push_back('0);
        end
        if (clr) begin ea.push_back(32'h14); ew.push_back(1'b0); ed.push_back('0); end
        chk("txn count", lg_add.size(), ea.size());
        m = (lg_add.size() < ea.size()) ? lg_add.size() : ea.size();
        for (int i = 0; i < m; i++) begin
            chk($sformatf("txn%0d add", i), lg_add[i], ea[i]);
            chk($sformatf("txn%0d wen", i), lg_wen[i], ew[i]);
            if (!ew[i]) chk($sformatf("txn%0d data", i), lg_data[i], ed[i]);
        end
    endtask

    initial begin
        logic [31:0] r;
        int n;

        // Reset state
        repeat (3) tick();
        chk("rst req", periph_req_o, 0);
        chk("rst add", periph_add_o, 0);
        chk("rst wen", periph_wen_o, 1);
        chk("rst data", periph_data_o, 0);
        chk("rst done/err/busy", {done_o, err_o, busy_o}, 0);
        chk("rst ctx", ctx_id_o, 0);
        chk("rst ready", job_ready_o, 0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        chk("ready after reset", job_ready_o, 1);
        tick();

        // Single acquire, event 50 cycles after trigger
        acq_q = '{32'h0000_0001};
        new_job();
        wait_trig_pulse(50, 1'b1, 1'b0);
        wait_done(2'd0, 8'd1);
        check_log(1, 1, 0);

        // Three busy acquires then ctx 2; evt/abort before WAIT_EVT are ignored
        acq_q = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002};
        new_job();
        evt_i = 1'b1; abort_i = 1'b1; tick(); evt_i = 1'b0; abort_i = 1'b0;
        wait_trig_pulse($urandom_range(5, 40), 1'b1, 1'b0);
        wait_done(2'd0, 8'd2);
        check_log(4, 1, 0);

        // Acquire never succeeds: ctx_id keeps its previous value
        acq_dflt = 32'hFFFF_FFFF;
        new_job();
        wait_done(2'd1, 8'd2);
        check_log(MAXR, 0, 0);

        // Timeout: WAIT_EVT lasts TMO cycles, CLEAR's request registers one cycle later
        r = $urandom & 32'h7FFF_FFFF;
        acq_q = '{r};
        new_job();
        wait_done(2'd2, r[7:0]);
        check_log(1, 1, 1);
        chk("timeout clear cycle", clr_cyc - trig_cyc, TMO + 1);

        // evt and abort together: evt wins
        acq_q = '{32'h0000_0003};
        new_job();
        wait_trig_pulse($urandom_range(5, 30), 1'b1, 1'b1);
        wait_done(2'd0, 8'd3);
        check_log(1, 1, 0);

        // abort alone
        acq_q = '{32'h0000_0004};
        new_job();
        wait_trig_pulse(10, 1'b0, 1'b1);
        wait_done(2'd3, 8'd4);
        check_log(1, 1, 1);

        // Reset during PROG word 5 with gnt withheld
        acq_q = '{32'h0000_0005};
        new_job();
        n = 0;
        while (lg_add.size() < 6 && n < 500) begin tick(); n++; end
        hold_gnt = 1'b1;
        n = 0;
        while (!periph_req_o && n < 20) begin tick(); n++; end
        chk("word5 req", periph_req_o, 1);
        chk("word5 add", periph_add_o, 32'h54);
        #2 rst_i = 1'b1;
        #1;
        chk("mid-reset req", periph_req_o, 0);
        chk("mid-reset busy/done", {busy_o, done_o}, 0);
        chk("mid-reset ready", job_ready_o, 0);
        hold_gnt = 1'b0;
        acq_q.delete();
        tick();
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        chk("ready after mid reset", job_ready_o, 1);
        repeat (5) tick();
        chk("no replay req", periph_req_o, 0);
        chk("no replay log", lg_add.size(), 6);

        // Recovery job
        r = $urandom & 32'h7FFF_FFFF;
        acq_q = '{r};
        new_job();
        wait_trig_pulse($urandom_range(1, 60), 1'b1, 1'b0);
        wait_done(2'd0, r[7:0]);
        check_log(1, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
